// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller for the asynchronous FIFO: producer handshake, RAM write port,
// Gray write pointer export, read-pointer synchroniser, full / almost-full / fill level.
module async_fifo_wr_ctrl #(
    parameter int unsigned DW           = 16,
    parameter int unsigned AW           = 3,
    parameter int unsigned AFULL_THRESH = 6,
    parameter int unsigned STALL_CW     = 8
) (
    input  logic                wr_clk,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [DW-1:0]       in_data,
    output logic                in_ready,
    input  logic [AW:0]         rd_ptr_gray,
    output logic                mem_we,
    output logic [AW-1:0]       mem_wr_addr,
    output logic [DW-1:0]       mem_data,
    output logic [AW:0]         wr_ptr_gray,
    output logic                full,
    output logic                almost_full,
    output logic [AW:0]         fill_level,
    output logic [STALL_CW-1:0] stall_cnt,
    input  logic                stall_clr
);

    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THRESH);

    logic [AW:0]         wr_bin_q, wr_bin_d;
    logic [AW:0]         wr_gray_q, wr_gray_d;
    logic [AW:0]         rq1_q, rq2_q;
    logic [STALL_CW-1:0] stall_q, stall_d;
    logic [AW:0]         rd_bin_s;
    logic [AW:0]         full_gray;
    logic                full_s;
    logic                accept;

    // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
    always_comb begin
        full_gray = {~rq2_q[AW:AW-1], rq2_q[AW-2:0]};
        full_s    = (wr_gray_q == full_gray);
        accept    = in_valid & ~full_s;
    end

    always_comb begin
        logic [AW:0] b;
        b     = '0;
        b[AW] = rq2_q[AW];
        for (int unsigned i = AW; i > 0; i--) begin
            b[i-1] = b[i] ^ rq2_q[i-1];
        end
        rd_bin_s = b;
    end

    always_comb begin
        wr_bin_d  = accept ? wr_bin_q + 1'b1 : wr_bin_q;
        wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    end

    // Clear wins over increment; the counter sticks at all-ones instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (in_valid && full_s && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge wr_clk or posedge clr) begin
        if (clr) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            rq1_q     <= '0;
            rq2_q     <= '0;
            stall_q   <= '0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            rq1_q     <= rd_ptr_gray;
            rq2_q     <= rq1_q;
            stall_q   <= stall_d;
        end
    end

    assign in_ready    = ~full_s;
    assign full        = full_s;
    assign mem_we      = in_valid & ~full_s & ~clr;
    assign mem_wr_addr = wr_bin_q[AW-1:0];
    assign mem_data    = in_data;
    assign wr_ptr_gray = wr_gray_q;
    assign fill_level  = wr_bin_q - rd_bin_s;
    assign almost_full = (fill_level >= AFULL_LVL);
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Self-checking bench for async_fifo_wr_ctrl; RAM writes are checked against a scoreboard
// of expected (address, data) pairs pushed when each word is offered.
module tb_async_fifo_wr_ctrl;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        wr_clk = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [3:0]  rd_ptr_gray = '0;
    logic        mem_we;
    logic [2:0]  mem_wr_addr;
    logic [15:0] mem_data;
    logic [3:0]  wr_ptr_gray;
    logic        full;
    logic        almost_full;
    logic [3:0]  fill_level;
    logic [7:0]  stall_cnt;
    logic        stall_clr = 1'b0;

    int  n_checks = 0;
    int  n_fail = 0;
    wr_t sb[$];

    async_fifo_wr_ctrl #(.DW(16), .AW(3), .AFULL_THRESH(6), .STALL_CW(8)) dut (
        .wr_clk(wr_clk), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .rd_ptr_gray(rd_ptr_gray), .mem_we(mem_we),
        .mem_wr_addr(mem_wr_addr), .mem_data(mem_data), .wr_ptr_gray(wr_ptr_gray),
        .full(full), .almost_full(almost_full), .fill_level(fill_level),
        .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    always #5 wr_clk = ~wr_clk;

    // Sample the write port 1 time unit before the capturing edge.
    always @(negedge wr_clk) begin
        wr_t e;
        #4;
        if (mem_we === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got write addr %0d data %h, expected no write", mem_wr_addr, mem_data);
            end else begin
                e = sb.pop_front();
                if (mem_wr_addr !== e.addr || mem_data !== e.data) begin
                    n_fail++;
                    $display("FAIL ram_write: got addr %0d data %h, expected addr %0d data %h",
                             mem_wr_addr, mem_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_word(input logic [2:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        #2 clr = 1'b1;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, full, almost_full, fill_level, wr_ptr_gray, stall_cnt, mem_we} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold: got rdy=%b full=%b af=%b fill=%0d gray=%h stall=%0d we=%b, expected 1 0 0 0 0 0 0",
                     in_ready, full, almost_full, fill_level, wr_ptr_gray, stall_cnt, mem_we);
        end
        in_valid = 1'b0;
        @(negedge wr_clk);
        clr = 1'b0;
        @(negedge wr_clk);
        n_checks++;
        if ({in_ready, full, almost_full, fill_level, wr_ptr_gray, mem_we, mem_wr_addr} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b full=%b af=%b fill=%0d gray=%h we=%b addr=%0d, expected 1 0 0 0 0 0 0",
                     in_ready, full, almost_full, fill_level, wr_ptr_gray, mem_we, mem_wr_addr);
        end
    endtask

    task automatic test_fill();
        rd_ptr_gray = 4'b0000;
        for (int n = 0; n < 8; n++) begin
            @(negedge wr_clk);
            n_checks++;
            if (fill_level !== 4'(n) || almost_full !== (n >= 6) || full !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_step%0d: got fill=%0d af=%b full=%b rdy=%b, expected fill=%0d af=%b full=0 rdy=1",
                         n, fill_level, almost_full, full, in_ready, n, (n >= 6));
            end
            in_valid = 1'b1;
            in_data  = 16'hA000 + 16'(n);
            push_word(3'(n), in_data);
        end
        @(negedge wr_clk);
        #1;
        n_checks++;
        if ({full, in_ready, almost_full, fill_level, wr_ptr_gray, mem_we, stall_cnt} !== {1'b1, 1'b0, 1'b1, 4'd8, 4'b1100, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL full_state: got full=%b rdy=%b af=%b fill=%0d gray=%b we=%b stall=%0d, expected 1 0 1 8 1100 0 0",
                     full, in_ready, almost_full, fill_level, wr_ptr_gray, mem_we, stall_cnt);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_release();
        @(negedge wr_clk);
        rd_ptr_gray = 4'b0001;
        in_valid    = 1'b1;
        in_data     = 16'hB000;
        push_word(3'd0, 16'hB000);
        @(negedge wr_clk);
        n_checks++;
        if (full !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL release_edge1: got full=%b rdy=%b, expected full=1 rdy=0", full, in_ready);
        end
        @(negedge wr_clk);
        n_checks++;
        if (full !== 1'b0 || in_ready !== 1'b1 || fill_level !== 4'd7 || mem_wr_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL release_edge2: got full=%b rdy=%b fill=%0d addr=%0d, expected full=0 rdy=1 fill=7 addr=0",
                     full, in_ready, fill_level, mem_wr_addr);
        end
        @(negedge wr_clk);
        n_checks++;
        if (full !== 1'b1 || fill_level !== 4'd8 || wr_ptr_gray !== 4'b1101 || stall_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL refill: got full=%b fill=%0d gray=%b stall=%0d, expected full=1 fill=8 gray=1101 stall=2",
                     full, fill_level, wr_ptr_gray, stall_cnt);
        end
    endtask

    task automatic test_stall();
        stall_clr = 1'b1;
        @(negedge wr_clk);
        stall_clr = 1'b0;
        n_checks++;
        if (stall_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL stall_clr_prio: got %0d, expected 0", stall_cnt);
        end
        repeat (100) @(negedge wr_clk);
        n_checks++;
        if (stall_cnt !== 8'd100) begin
            n_fail++;
            $display("FAIL stall_count: got %0d, expected 100", stall_cnt);
        end
        repeat (200) @(negedge wr_clk);
        n_checks++;
        if (stall_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL stall_saturate: got %0d, expected 255", stall_cnt);
        end
        stall_clr = 1'b1;
        @(negedge wr_clk);
        stall_clr = 1'b0;
        n_checks++;
        if (stall_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL stall_clr_during: got %0d, expected 0", stall_cnt);
        end
        @(negedge wr_clk);
        n_checks++;
        if (stall_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL stall_restart: got %0d, expected 1", stall_cnt);
        end
        in_valid  = 1'b0;
        stall_clr = 1'b1;
        @(negedge wr_clk);
        stall_clr = 1'b0;
        n_checks++;
        if (stall_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL stall_clr_idle: got %0d, expected 0", stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clr = 1'b1;
        rd_ptr_gray = 4'b0000;
        @(negedge wr_clk);
        clr = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge wr_clk);
            in_valid = 1'b1;
            in_data  = 16'hE000 + 16'(n);
            push_word(3'(n), in_data);
        end
        @(negedge wr_clk);
        in_valid = 1'b0;
        n_checks++;
        if (fill_level !== 4'd5 || almost_full !== 1'b0 || wr_ptr_gray !== 4'b0111) begin
            n_fail++;
            $display("FAIL pre_clr_fill: got fill=%0d af=%b gray=%b, expected fill=5 af=0 gray=0111",
                     fill_level, almost_full, wr_ptr_gray);
        end
        @(posedge wr_clk);
        #2;
        in_valid = 1'b1;
        clr      = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, full, almost_full, fill_level, wr_ptr_gray, stall_cnt, mem_we, mem_wr_addr} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL async_clr: got rdy=%b full=%b af=%b fill=%0d gray=%h stall=%0d we=%b addr=%0d, expected 1 0 0 0 0 0 0 0",
                     in_ready, full, almost_full, fill_level, wr_ptr_gray, stall_cnt, mem_we, mem_wr_addr);
        end
        @(negedge wr_clk);
        clr     = 1'b0;
        in_data = 16'hD000;
        push_word(3'd0, 16'hD000);
        @(negedge wr_clk);
        in_valid = 1'b0;
        n_checks++;
        if (fill_level !== 4'd1 || wr_ptr_gray !== 4'b0001) begin
            n_fail++;
            $display("FAIL post_clr_accept: got fill=%0d gray=%b, expected fill=1 gray=0001", fill_level, wr_ptr_gray);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_g [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                   4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        logic [3:0] prev;
        int         exp_fill;
        @(negedge wr_clk);
        clr = 1'b1;
        rd_ptr_gray = 4'b0000;
        @(negedge wr_clk);
        clr  = 1'b0;
        prev = 4'h0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge wr_clk);
            exp_fill = (k < 4) ? k : 4;
            n_checks++;
            if (wr_ptr_gray !== exp_g[k] || fill_level !== 4'(exp_fill) || in_ready !== 1'b1 || almost_full !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_step%0d: got gray=%h fill=%0d rdy=%b af=%b, expected gray=%h fill=%0d rdy=1 af=0",
                         k, wr_ptr_gray, fill_level, in_ready, almost_full, exp_g[k], exp_fill);
            end
            if (k > 0) begin
                n_checks++;
                if ($countones(wr_ptr_gray ^ prev) != 1) begin
                    n_fail++;
                    $display("FAIL wrap_onebit%0d: got %h -> %h, expected exactly one bit change", k, prev, wr_ptr_gray);
                end
            end
            prev = wr_ptr_gray;
            rd_ptr_gray = (k >= 2) ? exp_g[k-2] : 4'h0;
            if (k < 16) begin
                in_valid = 1'b1;
                in_data  = 16'hC000 + 16'(k);
                push_word(3'(k), in_data);
            end else begin
                in_valid = 1'b0;
            end
        end
        repeat (2) @(negedge wr_clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d words never written, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
Write-side controller for the 8x16 asynchronous dual-port RAM. It sits directly upstream of the RAM.
- Accepts words from a producer over a valid/ready handshake.
- Drives the RAM write port: write enable, write address and write data.
- Keeps the FIFO write pointer and exports it in Gray code to the read domain.
- Synchronises the read domain's Gray pointer into wr_clk and derives full, almost-full and fill level from it.

Parameters:
DW, 16, data width; must match the RAM word width.
AW, 3, RAM address width; FIFO depth is 2**AW = 8.
AFULL_THRESH, 6, fill level at or above which almost_full asserts (range 1..2**AW).
STALL_CW, 8, width of the saturating stall counter.

Ports:
wr_clk  input  1  write-domain clock; all flops in this block use it.
clr  input  1  reset, asynchronous, active-high; shared with the RAM clr.
in_valid  input  1  producer has a word on in_data.
in_data  input  DW  producer data.
in_ready  output  1  block can accept a word this cycle; equals ~full.
rd_ptr_gray  input  AW+1  read pointer in Gray code, from the rd_clk domain; may change at any time.
mem_we  output  1  RAM write enable.
mem_wr_addr  output  AW  RAM write address.
mem_data  output  DW  RAM write data.
wr_ptr_gray  output  AW+1  registered write pointer in Gray code, to the read domain.
full  output  1  FIFO full as seen in the write domain.
almost_full  output  1  fill_level >= AFULL_THRESH.
fill_level  output  AW+1  occupancy as seen in the write domain, 0..8.
stall_cnt  output  STALL_CW  saturating count of cycles with in_valid=1 and in_ready=0.
stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- State registers:
  - wr_bin, AW+1 bits, binary write pointer.
  - wr_gray, AW+1 bits, registered Gray of wr_bin.
  - rq1 and rq2, two-flop synchroniser on rd_ptr_gray.
  - stall_cnt.
- Reset: clr=1 asynchronously clears all state registers to 0. While clr is high and after it falls:
  - wr_ptr_gray=0, full=0, almost_full=0, fill_level=0, in_ready=1, stall_cnt=0.
  - mem_we follows in_valid, except that it is forced to 0 while clr is high.
- Accept rule: a word is accepted at a rising wr_clk edge when in_valid=1 and in_ready=1 (and clr=0).
- Write port timing (combinational, zero latency):
  - mem_we = in_valid & in_ready & ~clr.
  - mem_wr_addr = wr_bin[AW-1:0].
  - mem_data = in_data.
  - The RAM captures the word on the same edge on which the pointer advances.
- Pointer update on accept:
  - wr_bin <= wr_bin+1, modulo 2**(AW+1). Wrap is natural: after 16 accepts wr_bin returns to 0.
  - wr_gray <= (wr_bin+1) ^ ((wr_bin+1)>>1).
  - wr_ptr_gray = wr_gray. Exactly one bit changes per accept, and it only ever comes from the flop.
- Synchroniser: on every wr_clk edge, rq1 <= rd_ptr_gray and rq2 <= rq1. Only rq2 is used by the logic.
- Full:
  - full = (wr_gray == {~rq2[AW:AW-1], rq2[AW-2:0]}), decoded from flops only.
  - Full is pessimistic: it drops no earlier than 2 wr_clk edges after rd_ptr_gray changes.
- Fill level:
  - rd_bin_s = Gray-to-binary(rq2).
  - fill_level = wr_bin - rd_bin_s, modulo 2**(AW+1); the result never exceeds 8.
  - almost_full = (fill_level >= AFULL_THRESH).
- Simultaneous events: an accept and a read-pointer change in the same cycle are independent. The new fill level is wr_bin+1 minus the rq2 value at that edge.
- Stall counter:
  - Increments when in_valid & ~in_ready.
  - Saturates at 2**STALL_CW-1 and does not wrap.
  - stall_clr has priority over increment, giving 0 on the next edge.
- Backpressure: no data is dropped. The producer must hold in_data stable while in_valid=1 and in_ready=0. Violating this is a producer error that the block does not detect.
- Reset mid-operation: pointers return to 0 and the RAM is cleared by the same clr. The read side must be reset by the same clr so that rd_ptr_gray also returns to 0.

Test Plan:
1. Reset, in_valid=0 -> in_ready=1, full=0, fill_level=0, wr_ptr_gray=0, mem_we=0.
2. Hold rd_ptr_gray=0 and drive in_valid=1 with data 16'hA000+n:
   - Expect mem_wr_addr 0..7 with mem_we=1 for 8 cycles.
   - After the 8th accept: full=1, in_ready=0, fill_level=8, wr_ptr_gray=4'b1100.
   - almost_full asserts after the 6th accept.
3. From the full state, set rd_ptr_gray=4'b0001 -> full stays 1 for 1 edge and clears after the 2nd edge. fill_level=7. Exactly one further word is accepted at address 0.
4. Wrap check: 16 accepts, with rd_ptr_gray tracking the write pointer 2 cycles later -> wr_ptr_gray sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. Exactly one bit toggles per step.
5. Stall: hold the full state with in_valid=1 for 300 cycles -> stall_cnt saturates at 255. Pulse stall_clr -> 0 on the next edge. A stall_clr pulse during a stall also gives 0 on that edge.
6. Assert clr asynchronously mid-cycle with fill_level=5 -> all outputs return to their reset values immediately. After release, the first accept writes address 0.
